prv32_id_ex_stage: RTL and testbench

ID/EX pipeline register and operand-forwarding stage directly upstream of the EX-stage ALU. It captures decoded fields each cycle and resolves data hazards by forwarding from EX/MEM and MEM/WB. It drives the ALU inputs a, b, shamt and alufn, and raises a load-use stall toward fetch/decode. Flush and stall control from the hazard/branch unit is honoured here.

---
 rtl/prv32_id_ex_stage.sv | 135 +++++++++++++
 tb/tb_prv32_id_ex_stage.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/prv32_id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding feeding the EX-stage ALU.
// Also detects load-use hazards and turns flushes and stalls into bubbles.
module prv32_id_ex_stage #(
  parameter int XLEN   = 32,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [3:0]      id_alufn,
  input  logic            id_alusrc,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            flush,
  input  logic [4:0]      exmem_rd,
  input  logic            exmem_regwrite,
  input  logic [XLEN-1:0] exmem_result,
  input  logic [4:0]      memwb_rd,
  input  logic            memwb_regwrite,
  input  logic [XLEN-1:0] memwb_result,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      alu_shamt,
  output logic [3:0]      alu_alufn,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_store_data,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            load_use_stall
);

  logic            ex_valid_reg;
  logic [XLEN-1:0] ex_pc_reg;
  logic [XLEN-1:0] ex_imm_reg;
  logic [4:0]      ex_rd_reg;
  logic [3:0]      ex_alufn_reg;
  logic            ex_alusrc_reg;
  logic            ex_regwrite_reg;
  logic            ex_memread_reg;
  logic            ex_memwrite_reg;
  logic            capture;

  logic [1:0][XLEN-1:0] id_rs_data;
  logic [1:0][4:0]      id_rs_idx;
  logic [1:0][XLEN-1:0] fwd;

  assign id_rs_data = {id_rs2_data, id_rs1_data};
  assign id_rs_idx  = {id_rs2, id_rs1};

  // A load in EX cannot supply its data until MEM/WB, so hold decode for one cycle.
  assign load_use_stall = ex_valid_reg & ex_memread_reg & (ex_rd_reg != 5'd0) & id_valid &
                          ((ex_rd_reg == id_rs1) | ((ex_rd_reg == id_rs2) & ~id_alusrc));

  assign capture = ~(flush | load_use_stall);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_reg    <= 1'b0;
      ex_pc_reg       <= '0;
      ex_imm_reg      <= '0;
      ex_rd_reg       <= 5'd0;
      ex_alufn_reg    <= 4'd0;
      ex_alusrc_reg   <= 1'b0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_memwrite_reg <= 1'b0;
    end else if (!capture) begin
      // Bubble: only the valid/control bits and alufn are forced; data fields hold.
      ex_valid_reg    <= 1'b0;
      ex_alufn_reg    <= 4'd0;
      ex_regwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_memwrite_reg <= 1'b0;
    end else begin
      ex_valid_reg    <= id_valid;
      ex_pc_reg       <= id_pc;
      ex_imm_reg      <= id_imm;
      ex_rd_reg       <= id_rd;
      ex_alufn_reg    <= id_alufn;
      ex_alusrc_reg   <= id_alusrc;
      ex_regwrite_reg <= id_regwrite;
      ex_memread_reg  <= id_memread;
      ex_memwrite_reg <= id_memwrite;
    end
  end

  // Operand 0 is rs1, operand 1 is rs2; each has its own register slice and forwarding mux.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [XLEN-1:0] data_reg;
    logic [4:0]      idx_reg;
    logic            hit_exmem;
    logic            hit_memwb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_reg <= '0;
        idx_reg  <= 5'd0;
      end else if (capture) begin
        data_reg <= id_rs_data[gi];
        idx_reg  <= id_rs_idx[gi];
      end
    end

    // x0 is never forwarded; EX/MEM wins over MEM/WB as the younger producer.
    assign hit_exmem = FWD_EN & exmem_regwrite & (exmem_rd != 5'd0) & (exmem_rd == idx_reg);
    assign hit_memwb = FWD_EN & memwb_regwrite & (memwb_rd != 5'd0) & (memwb_rd == idx_reg);
    assign fwd[gi]   = hit_exmem ? exmem_result :
                       hit_memwb ? memwb_result : data_reg;
  end

  assign alu_a         = fwd[0];
  assign alu_b         = ex_alusrc_reg ? ex_imm_reg : fwd[1];
  assign alu_shamt     = alu_b[4:0];
  assign alu_alufn     = ex_alufn_reg;
  assign ex_store_data = fwd[1];

  assign ex_valid    = ex_valid_reg;
  assign ex_pc       = ex_pc_reg;
  assign ex_rd       = ex_rd_reg;
  assign ex_regwrite = ex_valid_reg & ex_regwrite_reg;
  assign ex_memread  = ex_valid_reg & ex_memread_reg;
  assign ex_memwrite = ex_valid_reg & ex_memwrite_reg;

endmodule

// File: tb/tb_prv32_id_ex_stage.sv
// Directed bench for prv32_id_ex_stage: forwarding priority, load-use stall, flush and async reset.
module tb_prv32_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alufn;
  logic        id_alusrc, id_regwrite, id_memread, id_memwrite, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
  logic [4:0]  alu_shamt, ex_rd;
  logic [3:0]  alu_alufn;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_stall;

  int checks = 0;
  int failures = 0;

  prv32_id_ex_stage #(.XLEN(32), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alufn(id_alufn),
    .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .flush(flush),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_alufn(alu_alufn),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alufn = 0; id_alusrc = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0;
  endtask

  task automatic fwd_clear();
    exmem_rd = 0; exmem_regwrite = 0; exmem_result = 0;
    memwb_rd = 0; memwb_regwrite = 0; memwb_result = 0;
  endtask

  initial begin
    rst = 1; flush = 0;
    id_clear(); fwd_clear();
    #3;
    check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("rst_alufn", {28'd0, alu_alufn}, 32'd0);
    check_eq("rst_alu_a", alu_a, 32'd0);
    check_eq("rst_alu_b", alu_b, 32'd0);
    check_eq("rst_stall", {31'd0, load_use_stall}, 32'd0);
    @(negedge clk); rst = 0;
    tick();

    // addi x5,x0,7
    id_valid = 1; id_pc = 32'h100; id_rd = 5; id_imm = 7; id_alusrc = 1; id_regwrite = 1;
    tick();
    check_eq("addi_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("addi_alu_b", alu_b, 32'd7);
    check_eq("addi_pc", ex_pc, 32'h100);
    check_eq("addi_regwrite", {31'd0, ex_regwrite}, 32'd1);
    // add x6,x5,x5 with x5 coming from EX/MEM
    id_clear(); id_valid = 1; id_pc = 32'h104; id_rs1 = 5; id_rs2 = 5; id_rd = 6; id_regwrite = 1;
    tick();
    exmem_rd = 5; exmem_regwrite = 1; exmem_result = 7;
    #1;
    check_eq("add_fwd_a", alu_a, 32'd7);
    check_eq("add_fwd_b", alu_b, 32'd7);
    check_eq("add_alufn", {28'd0, alu_alufn}, 32'd0);
    check_eq("add_rd", {27'd0, ex_rd}, 32'd6);

    // Forwarding priority on rs1=x3
    id_clear(); fwd_clear(); id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h99; id_alufn = 4'd7; id_rd = 9;
    tick();
    exmem_rd = 3; exmem_regwrite = 1; exmem_result = 32'h10;
    memwb_rd = 3; memwb_regwrite = 1; memwb_result = 32'h20;
    #1 check_eq("prio_exmem", alu_a, 32'h10);
    check_eq("prio_alufn", {28'd0, alu_alufn}, 32'd7);
    exmem_regwrite = 0;
    #1 check_eq("prio_memwb", alu_a, 32'h20);
    memwb_regwrite = 0;
    #1 check_eq("prio_regfile", alu_a, 32'h99);

    // lw x4 then add x8,x4,x1
    id_clear(); fwd_clear(); id_valid = 1; id_rs1 = 2; id_rd = 4; id_alusrc = 1;
    id_memread = 1; id_regwrite = 1;
    tick();
    check_eq("lw_memread", {31'd0, ex_memread}, 32'd1);
    id_clear(); id_valid = 1; id_rs1 = 4; id_rs2 = 1; id_rs2_data = 32'h11; id_rd = 8; id_regwrite = 1;
    #1 check_eq("lu_stall_on", {31'd0, load_use_stall}, 32'd1);
    tick();
    exmem_rd = 4; exmem_regwrite = 1; exmem_result = 32'h400;
    #1;
    check_eq("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("lu_bubble_regwr", {31'd0, ex_regwrite}, 32'd0);
    check_eq("lu_bubble_alufn", {28'd0, alu_alufn}, 32'd0);
    check_eq("lu_stall_off", {31'd0, load_use_stall}, 32'd0);
    tick();
    exmem_rd = 0; exmem_regwrite = 0; memwb_rd = 4; memwb_regwrite = 1; memwb_result = 32'hDEAD;
    #1;
    check_eq("lu_add_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("lu_add_a", alu_a, 32'hDEAD);
    check_eq("lu_add_b", alu_b, 32'h11);
    check_eq("lu_add_rd", {27'd0, ex_rd}, 32'd8);

    // Flush while decode holds sw
    id_clear(); fwd_clear(); id_valid = 1; id_memwrite = 1; id_alusrc = 1; id_imm = 8; flush = 1;
    tick();
    flush = 0;
    check_eq("flush_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("flush_memwrite", {31'd0, ex_memwrite}, 32'd0);
    // sw with store data forwarded from MEM/WB
    id_rs2 = 7; id_rs2_data = 32'h1;
    tick();
    memwb_rd = 7; memwb_regwrite = 1; memwb_result = 32'h77;
    #1;
    check_eq("sw_store_data", ex_store_data, 32'h77);
    check_eq("sw_alu_b", alu_b, 32'd8);
    check_eq("sw_memwrite", {31'd0, ex_memwrite}, 32'd1);

    // Simultaneous flush and load-use stall: one bubble only
    id_clear(); fwd_clear(); id_valid = 1; id_rd = 9; id_memread = 1; id_regwrite = 1; id_alusrc = 1;
    tick();
    id_clear(); id_valid = 1; id_rs1 = 9; id_rd = 10; id_regwrite = 1; flush = 1;
    #1 check_eq("fs_stall_on", {31'd0, load_use_stall}, 32'd1);
    tick();
    flush = 0;
    check_eq("fs_bubble_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("fs_stall_off", {31'd0, load_use_stall}, 32'd0);
    tick();
    check_eq("fs_next_valid", {31'd0, ex_valid}, 32'd1);
    check_eq("fs_next_rd", {27'd0, ex_rd}, 32'd10);

    // x0 writer is never forwarded
    id_clear(); fwd_clear(); id_valid = 1; id_rd = 11;
    tick();
    exmem_rd = 0; exmem_regwrite = 1; exmem_result = 32'hFFFF;
    memwb_rd = 0; memwb_regwrite = 1; memwb_result = 32'hFFFF;
    #1 check_eq("x0_no_fwd", alu_a, 32'd0);
    // slli with shamt 31
    id_clear(); fwd_clear(); id_valid = 1; id_rd = 12; id_alusrc = 1; id_imm = 31; id_alufn = 4'd1;
    id_rs2 = 3; id_rs2_data = 32'h5;
    tick();
    check_eq("slli_shamt", {27'd0, alu_shamt}, 32'd31);
    check_eq("slli_alufn", {28'd0, alu_alufn}, 32'd1);

    // Async reset mid-cycle with a valid load in EX
    id_clear(); id_valid = 1; id_rd = 13; id_regwrite = 1; id_memread = 1; id_alufn = 4'd5;
    tick();
    check_eq("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    #2 rst = 1;
    #1;
    check_eq("arst_valid", {31'd0, ex_valid}, 32'd0);
    check_eq("arst_memread", {31'd0, ex_memread}, 32'd0);
    check_eq("arst_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check_eq("arst_alufn", {28'd0, alu_alufn}, 32'd0);
    check_eq("arst_rd", {27'd0, ex_rd}, 32'd0);
    @(negedge clk); rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
